// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave. A request handshake grants after WAIT_CYCLES and is followed by a one-cycle response.
// Define MEM_RESPONDER_BOUNDS_EN to compile in the address bounds check; otherwise addresses alias and err stays 0.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0]  CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off_p0;
  logic [AW-1:0] idx_p0;
  logic          in_range_p0;
  logic          unused_off;

  logic [31:0] rdata_p1;
  logic        vld_p1;
  logic        err_p1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Request stage: address decode
  assign off_p0     = addr - BASE_ADDR;
  assign idx_p0     = off_p0[AW+1:2];
  assign unused_off = ^{off_p0[31:AW+2], off_p0[1:0]};

`ifdef MEM_RESPONDER_BOUNDS_EN
  // Addresses below BASE_ADDR wrap to a huge offset, so one upper-bits test covers both ends.
  assign in_range_p0 = (off_p0[31:AW+2] == '0);
`else
  assign in_range_p0 = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = valid && !HAS_WAIT;
        if (valid && HAS_WAIT) begin
          state_n = WAIT;
          cnt_n   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (!valid) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          ready   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Gating with rst_n keeps a grant (and thus a write) from slipping through while reset is held.
    if (!rst_n) ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ready && write_en && in_range_p0) begin
      mem[idx_p0] <= merge_bytes(mem[idx_p0], wdata, byte_en);
    end
  end

  // Response stage: registered strobe, error and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= 32'h0;
    end else begin
      vld_p1 <= ready;
      err_p1 <= ready && !in_range_p0;
      if (ready && !write_en) begin
        rdata_p1 <= in_range_p0 ? mem[idx_p0] : 32'hDEAD_BEEF;
      end
    end
  end

  assign rvalid = vld_p1;
  assign err    = err_p1;
  assign rdata  = rdata_p1;

endmodule
